// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared encodings for the data-memory access unit: access
//               sizes, exception codes, the pending-FIFO entry layout and the
//               control state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Access size encodings (req_size / mem_size)
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Address-error exception codes
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;

  // Byte offset field is sized for the widest bus (64-bit, 8 lanes) so the
  // entry layout does not depend on DATA_W.
  localparam int PEND_OFF_W = 3;

  typedef struct packed {
    logic                  we;
    logic [1:0]            size;
    logic                  uns;
    logic [PEND_OFF_W-1:0] off;
    logic                  discard;
  } pend_entry_t;

  localparam int PEND_W           = $bits(pend_entry_t);
  localparam int PEND_DISCARD_BIT = 0;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } mau_state_e;

  // Number of bytes touched by an access of the given size.
  function automatic logic [3:0] size_nbytes(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mau_pending_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mau_pending_fifo
// Description : Circular FIFO of in-flight bus accesses. Holds one entry per
//               accepted request until its data phase completes.
//               A single "discard_all" input sets the discard bit of every
//               stored entry, including one written in the same cycle.
// Ports       : clk, resetn      - clock, asynchronous active-low reset
//               push, push_data  - write an entry (ignored when full)
//               pop              - retire the head entry (ignored when empty)
//               discard_all      - mark every entry as discarded
//               full, empty      - occupancy flags
//               head             - oldest entry
// Revision    : 1.0 - initial release
// ============================================================================
module mau_pending_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH       = 2,
  parameter int WIDTH       = PEND_W,
  parameter int DISCARD_BIT = PEND_DISCARD_BIT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             discard_all,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Push is judged against the current occupancy only: a pop in the same
  // cycle does not make room for a push into a full FIFO.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (discard_all) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i][DISCARD_BIT] = 1'b1;
      end
    end

    if (do_push) begin
      mem_d[wr_ptr_q]              = push_data;
      mem_d[wr_ptr_q][DISCARD_BIT] = push_data[DISCARD_BIT] | discard_all;
      wr_ptr_d                     = ptr_inc(wr_ptr_q);
    end

    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage data-memory access unit. Checks alignment, issues
//               requests on a split request/response SRAM-style bus, tracks
//               in-flight accesses in a pending FIFO, aligns and extends load
//               data, and raises address-error exceptions. A flush squashes
//               new requests and discards responses of in-flight accesses.
// Ports       : req_*        - access from the pipeline (valid/ready)
//               flush        - squash request, discard in-flight responses
//               mem_*        - bus request (mem_req/mem_addr_ok) and data
//                              phase (mem_data_ok/mem_rdata)
//               resp_*       - one-cycle completion pulse with load data
//               exc_*, bad_vaddr - registered address-error report
//               busy         - accesses in flight or draining
//               proto_err    - sticky: data_ok seen with nothing in flight
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_pc,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic                flush,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                exc_valid,
  output logic [4:0]          exc_code,
  output logic [ADDR_W-1:0]   bad_vaddr,
  output logic [ADDR_W-1:0]   exc_pc,
  output logic                busy,
  output logic                proto_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int LSB_W = $clog2(DATA_W);

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  mau_state_e          state_q, state_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                exc_valid_q, exc_valid_d;
  logic [4:0]          exc_code_q, exc_code_d;
  logic [ADDR_W-1:0]   bad_vaddr_q, bad_vaddr_d;
  logic [ADDR_W-1:0]   exc_pc_q, exc_pc_d;
  logic                proto_err_q, proto_err_d;

  // --------------------------------------------------------------------------
  // Request-side decode
  // --------------------------------------------------------------------------
  logic [3:0]       nbytes;
  logic [OFF_W-1:0] off;
  logic             misaligned;
  logic             take_ok;
  logic             do_push;
  logic             exc_take;
  pend_entry_t      push_entry;

  // Pending FIFO
  logic             fifo_full;
  logic             fifo_empty;
  logic             do_pop;
  pend_entry_t      fifo_head;
  logic [PEND_W-1:0] fifo_head_raw;

  assign nbytes = size_nbytes(req_size);
  assign off    = req_addr[OFF_W-1:0];

  // Doubleword accesses have no lane layout on a 32-bit bus, so they are
  // treated as address errors there.
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = req_addr[0];
      SZ_W:    misaligned = |req_addr[1:0];
      default: misaligned = (DATA_W == 32) ? 1'b1 : |req_addr[2:0];
    endcase
  end

  assign take_ok   = (state_q == ST_RUN) & ~flush;
  assign mem_req   = req_valid & take_ok & ~misaligned & ~fifo_full;
  // A misaligned access is consumed locally and never waits on the bus.
  assign req_ready = take_ok & (misaligned | (~fifo_full & mem_addr_ok));
  assign do_push   = mem_req & mem_addr_ok;
  assign exc_take  = req_valid & take_ok & misaligned;
  assign do_pop    = mem_data_ok & ~fifo_empty;

  assign mem_wr   = req_we;
  assign mem_size = req_size;
  assign mem_addr = req_addr;

  // Strobes cover [off, off+nbytes); write data is the low nbytes of
  // req_wdata copied into every lane group so the bus can pick any lane.
  always_comb begin
    logic [OFF_W-1:0] src_lane;
    mem_wstrb = '0;
    mem_wdata = '0;
    for (int i = 0; i < NB; i++) begin
      mem_wstrb[i] = req_we & (i >= int'(off)) & (i < int'(off) + int'(nbytes));
      src_lane     = OFF_W'(i) & OFF_W'(nbytes - 4'd1);
      mem_wdata[8*i +: 8] = req_wdata[{src_lane, 3'b000} +: 8];
    end
  end

  always_comb begin
    push_entry         = '0;
    push_entry.we      = req_we;
    push_entry.size    = req_size;
    push_entry.uns     = req_unsigned;
    push_entry.off     = PEND_OFF_W'(off);
    push_entry.discard = 1'b0;
  end

  mau_pending_fifo #(
    .DEPTH       (MAX_OUTST),
    .WIDTH       (PEND_W),
    .DISCARD_BIT (PEND_DISCARD_BIT)
  ) u_pending_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .push        (do_push),
    .push_data   (push_entry),
    .pop         (do_pop),
    .discard_all (flush),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .head        (fifo_head_raw)
  );

  assign fifo_head = pend_entry_t'(fifo_head_raw);

  // --------------------------------------------------------------------------
  // Response path: align the addressed bytes to bit 0, then extend.
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] rdata_sh;
  logic [DATA_W-1:0] load_data;
  logic [3:0]        head_nbytes;
  logic              sign_bit;
  logic              fill;

  always_comb begin
    rdata_sh    = mem_rdata >> {fifo_head.off, 3'b000};
    head_nbytes = size_nbytes(fifo_head.size);
    sign_bit    = 1'b0;
    case (fifo_head.size)
      SZ_B:    sign_bit = rdata_sh[7];
      SZ_H:    sign_bit = rdata_sh[15];
      SZ_W:    sign_bit = rdata_sh[31];
      default: sign_bit = rdata_sh[DATA_W-1];
    endcase
    fill      = sign_bit & ~fifo_head.uns;
    load_data = '0;
    for (int j = 0; j < NB; j++) begin
      load_data[8*j +: 8] = (4'(j) < head_nbytes) ? rdata_sh[8*j +: 8] : {8{fill}};
    end
    if (fifo_head.we) begin
      load_data = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and registered-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    resp_valid_d = do_pop & ~fifo_head.discard;
    resp_rdata_d = resp_rdata_q;
    exc_valid_d  = exc_take;
    exc_code_d   = exc_code_q;
    bad_vaddr_d  = bad_vaddr_q;
    exc_pc_d     = exc_pc_q;
    proto_err_d  = proto_err_q | (mem_data_ok & fifo_empty);

    if (resp_valid_d) begin
      resp_rdata_d = load_data;
    end

    if (exc_take) begin
      exc_code_d  = req_we ? EXC_ADES : EXC_ADEL;
      bad_vaddr_d = req_addr;
      exc_pc_d    = req_pc;
    end

    case (state_q)
      ST_RUN: begin
        if (flush && !fifo_empty) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && !flush) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_RUN;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      exc_valid_q  <= 1'b0;
      exc_code_q   <= '0;
      bad_vaddr_q  <= '0;
      exc_pc_q     <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      exc_valid_q  <= exc_valid_d;
      exc_code_q   <= exc_code_d;
      bad_vaddr_q  <= bad_vaddr_d;
      exc_pc_q     <= exc_pc_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign exc_valid  = exc_valid_q;
  assign exc_code   = exc_code_q;
  assign bad_vaddr  = bad_vaddr_q;
  assign exc_pc     = exc_pc_q;
  assign proto_err  = proto_err_q;
  assign busy       = ~fifo_empty | (state_q == ST_DRAIN);

  // Keeps the alignment-width constant tied to the bus width.
  if (LSB_W != OFF_W + 3) begin : g_width_guard
    $error("mem_access_unit: DATA_W must be 32 or 64");
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed bench for mem_access_unit. A 32-bit and a 64-bit
//               instance share most request inputs; each has its own
//               req_valid and mem_data_ok. Single accesses come from a
//               vector table; backpressure, flush/drain, protocol error and
//               asynchronous reset are hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        req_we, req_unsigned, flush, mem_addr_ok;
  logic [1:0]  req_size;
  logic [31:0] req_pc, req_addr;
  logic [63:0] req_wdata, mem_rdata;
  logic        a_req_valid, b_req_valid, a_data_ok, b_data_ok;

  logic        a_req_ready, a_mem_req, a_mem_wr, a_resp_valid, a_exc_valid, a_busy, a_proto_err;
  logic [1:0]  a_mem_size;
  logic [31:0] a_mem_addr, a_mem_wdata, a_resp_rdata, a_bad_vaddr, a_exc_pc;
  logic [3:0]  a_mem_wstrb;
  logic [4:0]  a_exc_code;

  logic        b_req_ready, b_mem_req, b_mem_wr, b_resp_valid, b_exc_valid, b_busy, b_proto_err;
  logic [1:0]  b_mem_size;
  logic [31:0] b_mem_addr, b_bad_vaddr, b_exc_pc;
  logic [63:0] b_mem_wdata, b_resp_rdata;
  logic [7:0]  b_mem_wstrb;
  logic [4:0]  b_exc_code;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .MAX_OUTST(2)) u_dut32 (
    .clk(clk), .resetn(resetn),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_pc(req_pc),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .flush(flush),
    .mem_req(a_mem_req), .mem_wr(a_mem_wr), .mem_size(a_mem_size),
    .mem_addr(a_mem_addr), .mem_wstrb(a_mem_wstrb), .mem_wdata(a_mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(a_data_ok), .mem_rdata(mem_rdata[31:0]),
    .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
    .exc_valid(a_exc_valid), .exc_code(a_exc_code), .bad_vaddr(a_bad_vaddr),
    .exc_pc(a_exc_pc), .busy(a_busy), .proto_err(a_proto_err)
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .MAX_OUTST(2)) u_dut64 (
    .clk(clk), .resetn(resetn),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_pc(req_pc),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .mem_req(b_mem_req), .mem_wr(b_mem_wr), .mem_size(b_mem_size),
    .mem_addr(b_mem_addr), .mem_wstrb(b_mem_wstrb), .mem_wdata(b_mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(b_data_ok), .mem_rdata(mem_rdata),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
    .exc_valid(b_exc_valid), .exc_code(b_exc_code), .bad_vaddr(b_bad_vaddr),
    .exc_pc(b_exc_pc), .busy(b_busy), .proto_err(b_proto_err)
  );

  // Selected-instance view used by the table loop.
  logic        sel64;
  logic        s_req_ready, s_mem_req, s_resp_valid, s_exc_valid, s_busy;
  logic [7:0]  s_wstrb;
  logic [63:0] s_wdata, s_rdata;
  logic [4:0]  s_exc_code;
  logic [31:0] s_bad_vaddr, s_exc_pc;

  always_comb begin
    s_req_ready  = sel64 ? b_req_ready  : a_req_ready;
    s_mem_req    = sel64 ? b_mem_req    : a_mem_req;
    s_resp_valid = sel64 ? b_resp_valid : a_resp_valid;
    s_exc_valid  = sel64 ? b_exc_valid  : a_exc_valid;
    s_busy       = sel64 ? b_busy       : a_busy;
    s_wstrb      = sel64 ? b_mem_wstrb  : {4'h0, a_mem_wstrb};
    s_wdata      = sel64 ? b_mem_wdata  : {32'h0, a_mem_wdata};
    s_rdata      = sel64 ? b_resp_rdata : {32'h0, a_resp_rdata};
    s_exc_code   = sel64 ? b_exc_code   : a_exc_code;
    s_bad_vaddr  = sel64 ? b_bad_vaddr  : a_bad_vaddr;
    s_exc_pc     = sel64 ? b_exc_pc     : a_exc_pc;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit        w64;
    bit        we;
    bit [1:0]  size;
    bit        uns;
    bit [31:0] pc;
    bit [31:0] addr;
    bit [63:0] wdata;
    bit [63:0] rdata;
    bit        exc;
    bit [4:0]  code;
    bit [7:0]  wstrb;
    bit [63:0] wexp;
    bit [63:0] res;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit w64, bit we, bit [1:0] size, bit uns, bit [31:0] pc,
                              bit [31:0] addr, bit [63:0] wdata, bit [63:0] rdata,
                              bit exc, bit [4:0] code, bit [7:0] wstrb,
                              bit [63:0] wexp, bit [63:0] res);
    vec_t v;
    v.w64 = w64; v.we = we; v.size = size; v.uns = uns; v.pc = pc; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.exc = exc; v.code = code; v.wstrb = wstrb;
    v.wexp = wexp; v.res = res;
    return v;
  endfunction

  // One access through the selected instance, bus always ready.
  task automatic run_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    sel64        = v.w64;
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_pc       = v.pc;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    mem_addr_ok  = 1'b1;
    if (v.w64) b_req_valid = 1'b1; else a_req_valid = 1'b1;
    #1;
    chk({t, " mem_req"}, s_mem_req, !v.exc);
    chk({t, " req_ready"}, s_req_ready, 1);
    if (!v.exc) chk({t, " wstrb"}, s_wstrb, v.wstrb);
    if (!v.exc && v.we) chk({t, " wdata"}, s_wdata, v.wexp);
    step();
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    if (v.exc) begin
      chk({t, " exc_valid"}, s_exc_valid, 1);
      chk({t, " exc_code"}, s_exc_code, v.code);
      chk({t, " bad_vaddr"}, s_bad_vaddr, v.addr);
      chk({t, " exc_pc"}, s_exc_pc, v.pc);
      chk({t, " busy_exc"}, s_busy, 0);
      step();
      chk({t, " exc_pulse"}, s_exc_valid, 0);
      chk({t, " exc_code_hold"}, s_exc_code, v.code);
    end else begin
      chk({t, " busy"}, s_busy, 1);
      chk({t, " no_exc"}, s_exc_valid, 0);
      mem_rdata = v.rdata;
      if (v.w64) b_data_ok = 1'b1; else a_data_ok = 1'b1;
      step();
      a_data_ok = 1'b0;
      b_data_ok = 1'b0;
      chk({t, " resp_valid"}, s_resp_valid, 1);
      chk({t, " resp_rdata"}, s_rdata, v.res);
      step();
      chk({t, " resp_pulse"}, s_resp_valid, 0);
      chk({t, " idle"}, s_busy, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; sel64 = 1'b0;
    req_we = 0; req_unsigned = 0; flush = 0; mem_addr_ok = 0; req_size = SZ_B;
    req_pc = '0; req_addr = '0; req_wdata = '0; mem_rdata = '0;
    a_req_valid = 0; b_req_valid = 0; a_data_ok = 0; b_data_ok = 0;

    //                w64 we size  uns pc            addr          wdata                  rdata                  exc code      strb   wexp                   res
    vecs.push_back(mk(0, 1, SZ_B, 0, 32'hBFC00000, 32'h00001003, 64'h000000A5,         64'hDEADBEEF,          0, 5'h0,     8'h08, 64'hA5A5A5A5,          64'h0));
    vecs.push_back(mk(0, 0, SZ_H, 0, 32'hBFC00004, 32'h00002002, 64'h0,                64'h80011234,          0, 5'h0,     8'h00, 64'h0,                 64'hFFFF8001));
    vecs.push_back(mk(0, 0, SZ_H, 1, 32'hBFC00008, 32'h00002002, 64'h0,                64'h80011234,          0, 5'h0,     8'h00, 64'h0,                 64'h00008001));
    vecs.push_back(mk(0, 0, SZ_W, 0, 32'hBFC00100, 32'h00003001, 64'h0,                64'h0,                 1, EXC_ADEL, 8'h00, 64'h0,                 64'h0));
    vecs.push_back(mk(0, 1, SZ_H, 0, 32'hBFC00104, 32'h00003001, 64'h0,                64'h0,                 1, EXC_ADES, 8'h00, 64'h0,                 64'h0));
    vecs.push_back(mk(0, 0, SZ_B, 0, 32'hBFC0000C, 32'h00004001, 64'h0,                64'h11228033,          0, 5'h0,     8'h00, 64'h0,                 64'hFFFFFF80));
    vecs.push_back(mk(0, 0, SZ_B, 1, 32'hBFC00010, 32'h00004001, 64'h0,                64'h11228033,          0, 5'h0,     8'h00, 64'h0,                 64'h00000080));
    vecs.push_back(mk(0, 0, SZ_W, 0, 32'hBFC00014, 32'h00005000, 64'h0,                64'hCAFEF00D,          0, 5'h0,     8'h00, 64'h0,                 64'hCAFEF00D));
    vecs.push_back(mk(0, 1, SZ_W, 0, 32'hBFC00018, 32'h00005004, 64'h12345678,         64'h0,                 0, 5'h0,     8'h0F, 64'h12345678,          64'h0));
    vecs.push_back(mk(0, 1, SZ_H, 0, 32'hBFC0001C, 32'h00006002, 64'hFFFFBEEF,         64'h0,                 0, 5'h0,     8'h0C, 64'hBEEFBEEF,          64'h0));
    vecs.push_back(mk(0, 0, SZ_D, 0, 32'hBFC00020, 32'h00007000, 64'h0,                64'h0,                 1, EXC_ADEL, 8'h00, 64'h0,                 64'h0));
    vecs.push_back(mk(0, 1, SZ_B, 0, 32'hBFC00024, 32'h00001000, 64'h0000005A,         64'h0,                 0, 5'h0,     8'h01, 64'h5A5A5A5A,          64'h0));
    vecs.push_back(mk(1, 0, SZ_D, 0, 32'hBFC00200, 32'h00001008, 64'h0,                64'h0123456789ABCDEF,  0, 5'h0,     8'h00, 64'h0,                 64'h0123456789ABCDEF));
    vecs.push_back(mk(1, 0, SZ_W, 0, 32'hBFC00204, 32'h0000100C, 64'h0,                64'h8000000012345678,  0, 5'h0,     8'h00, 64'h0,                 64'hFFFFFFFF80000000));
    vecs.push_back(mk(1, 0, SZ_W, 1, 32'hBFC00208, 32'h0000100C, 64'h0,                64'h8000000012345678,  0, 5'h0,     8'h00, 64'h0,                 64'h0000000080000000));
    vecs.push_back(mk(1, 0, SZ_D, 0, 32'hBFC0020C, 32'h00001004, 64'h0,                64'h0,                 1, EXC_ADEL, 8'h00, 64'h0,                 64'h0));
    vecs.push_back(mk(1, 1, SZ_B, 0, 32'hBFC00210, 32'h00001005, 64'h00000000000000A5, 64'h0,                 0, 5'h0,     8'h20, 64'hA5A5A5A5A5A5A5A5,  64'h0));
    vecs.push_back(mk(1, 1, SZ_D, 0, 32'hBFC00214, 32'h00001010, 64'h1122334455667788, 64'h0,                 0, 5'h0,     8'hFF, 64'h1122334455667788,  64'h0));
    vecs.push_back(mk(1, 0, SZ_H, 0, 32'hBFC00218, 32'h00001006, 64'h0,                64'h7FFF000000000000,  0, 5'h0,     8'h00, 64'h0,                 64'h0000000000007FFF));

    // Reset state
    repeat (2) step();
    chk("rst resp_valid", a_resp_valid, 0);
    chk("rst exc_valid", a_exc_valid, 0);
    chk("rst exc_code", a_exc_code, 0);
    chk("rst busy", a_busy, 0);
    chk("rst proto_err", a_proto_err, 0);
    chk("rst resp_rdata", a_resp_rdata, 0);
    chk("rst busy64", b_busy, 0);
    resetn = 1'b1;
    step();

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Backpressure: FIFO depth 2, data phase held off.
    sel64 = 1'b0; mem_addr_ok = 1'b1; a_data_ok = 1'b0;
    req_we = 0; req_size = SZ_W; req_unsigned = 0; req_pc = 32'hBFC00300;
    a_req_valid = 1'b1; req_addr = 32'h100; #1;
    chk("bp ready1", a_req_ready, 1);
    step();
    req_addr = 32'h104; #1;
    chk("bp ready2", a_req_ready, 1);
    step();
    req_addr = 32'h108; #1;
    chk("bp ready3 full", a_req_ready, 0);
    chk("bp mem_req3 full", a_mem_req, 0);
    chk("bp busy", a_busy, 1);
    step();
    a_data_ok = 1'b1; mem_rdata = 64'h11111111; #1;
    chk("bp ready on pop", a_req_ready, 0);
    step();
    a_data_ok = 1'b0;
    chk("bp resp1 valid", a_resp_valid, 1);
    chk("bp resp1 data", a_resp_rdata, 32'h11111111);
    #1;
    chk("bp ready3 after pop", a_req_ready, 1);
    chk("bp mem_req3", a_mem_req, 1);
    step();
    a_req_valid = 1'b0;
    a_data_ok = 1'b1; mem_rdata = 64'h22222222;
    step();
    chk("bp resp2 valid", a_resp_valid, 1);
    chk("bp resp2 data", a_resp_rdata, 32'h22222222);
    mem_rdata = 64'h33333333;
    step();
    a_data_ok = 1'b0;
    chk("bp resp3 valid", a_resp_valid, 1);
    chk("bp resp3 data", a_resp_rdata, 32'h33333333);
    step();
    chk("bp idle", a_busy, 0);

    // Flush with two loads in flight.
    a_req_valid = 1'b1; req_addr = 32'h200;
    step();
    req_addr = 32'h204;
    step();
    req_addr = 32'h208; flush = 1'b1; #1;
    chk("fl ready", a_req_ready, 0);
    chk("fl mem_req", a_mem_req, 0);
    step();
    flush = 1'b0; #1;
    chk("fl drain ready", a_req_ready, 0);
    chk("fl drain mem_req", a_mem_req, 0);
    chk("fl drain busy", a_busy, 1);
    a_req_valid = 1'b0;
    a_data_ok = 1'b1; mem_rdata = 64'h44444444;
    step();
    chk("fl resp1 dropped", a_resp_valid, 0);
    step();
    a_data_ok = 1'b0;
    chk("fl resp2 dropped", a_resp_valid, 0);
    chk("fl still draining", a_busy, 1);
    step();
    chk("fl back to run busy", a_busy, 0);
    chk("fl back to run ready", a_req_ready, 1);
    chk("fl no proto_err", a_proto_err, 0);

    // Data phase with nothing in flight.
    a_data_ok = 1'b1;
    step();
    a_data_ok = 1'b0;
    chk("pe set", a_proto_err, 1);
    chk("pe no resp", a_resp_valid, 0);
    step();
    chk("pe sticky", a_proto_err, 1);

    // Asynchronous reset with an access in flight.
    a_req_valid = 1'b1; req_addr = 32'h300;
    step();
    a_req_valid = 1'b0;
    chk("ar busy before", a_busy, 1);
    #2 resetn = 1'b0;
    #1;
    chk("ar busy cleared", a_busy, 0);
    chk("ar proto_err cleared", a_proto_err, 0);
    step();
    resetn = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
